// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package     : lsu_pkg                                                  |
// | Description : Shared funct3 encodings, FSM state type and lane helper  |
// |               functions for the load/store unit.                       |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
// Contents:
//   F3_*          RV32I load/store size encodings
//   lsu_state_t   FSM state type
//   strobe_of     byte-enable pattern for a size and (aligned) byte offset
//   extend_load   lane extraction plus sign/zero extension of a memory word
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } lsu_state_t;

  // Only funct3[1:0] selects the size; signedness does not affect strobes.
  function automatic logic [3:0] strobe_of(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
    logic [3:0] s;
    case (funct3[1:0])
      2'b00:   s = 4'b0001 << addr_lo;
      2'b01:   s = addr_lo[1] ? 4'b1100 : 4'b0011;
      2'b10:   s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] extend_load(input logic [2:0]  funct3,
                                              input logic [1:0]  addr_lo,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{addr_lo, 3'b000} +: 8];
    h = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_W:    r = word;
      F3_BU:   r = {24'b0, b};
      F3_HU:   r = {16'b0, h};
      default: r = 32'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface   : load_store_unit_if                                       |
// | Description : Core request/response handshake plus data-memory port    |
// |               of the load/store unit.                                  |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
// Signals:
//   req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata  core request
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err                      core response
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata                 data memory
// Modports:
//   slave  - the load/store unit
//   master - the environment (core and data memory together)
interface load_store_unit_if #(
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 10
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  logic              mem_en;
  logic [3:0]        mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
           mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
           mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface
`default_nettype wire

// File: rtl/load_store_unit_align.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : lsu_align                                                |
// | Description : Combinational request legality, address alignment,      |
// |               store strobe/lane replication and load extension.        |
// | Revision    : 1.0 - initial release                                    |
// | Build macro : LSU_MISALIGN_TRAP_EN - misaligned H/HU/W become errors;  |
// |               otherwise the low address bits are forced to alignment.  |
// +------------------------------------------------------------------------+
// Ports:
//   req_funct3/req_we/req_addr_lo/req_wdata  incoming request fields
//   req_illegal    request must be answered with an error, no access
//   eff_addr_lo    byte offset after alignment
//   req_strobe     byte enables for a store at eff_addr_lo
//   req_lanes      store data replicated across the lanes
//   ld_funct3/ld_addr_lo/ld_word  captured load fields and memory word
//   ld_data        extended load result
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  req_funct3,
  input  logic        req_we,
  input  logic [1:0]  req_addr_lo,
  input  logic [31:0] req_wdata,
  output logic        req_illegal,
  output logic [1:0]  eff_addr_lo,
  output logic [3:0]  req_strobe,
  output logic [31:0] req_lanes,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic w_bad_code;

  // 011/110/111 are undefined; unsigned variants exist only for loads.
  assign w_bad_code = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                      (req_funct3 == 3'b111) || (req_we && req_funct3[2]);

  always_comb begin
    eff_addr_lo = req_addr_lo;
    case (req_funct3[1:0])
      2'b01:   eff_addr_lo = {req_addr_lo[1], 1'b0};
      2'b10:   eff_addr_lo = 2'b00;
      default: eff_addr_lo = req_addr_lo;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // Any bit the alignment would have cleared marks the access as misaligned.
  assign req_illegal = w_bad_code || (eff_addr_lo != req_addr_lo);
`else
  assign req_illegal = w_bad_code;
`endif

  assign req_strobe = strobe_of(req_funct3, eff_addr_lo);

  always_comb begin
    case (req_funct3[1:0])
      2'b00:   req_lanes = {4{req_wdata[7:0]}};
      2'b01:   req_lanes = {2{req_wdata[15:0]}};
      default: req_lanes = req_wdata;
    endcase
  end

  assign ld_data = extend_load(ld_funct3, ld_addr_lo, ld_word);

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : load_store_unit                                          |
// | Description : One-at-a-time load/store unit between the memory stage   |
// |               and a single-port word-addressed data memory.            |
// | Revision    : 1.0 - initial release                                    |
// | Build macro : LSU_MISALIGN_TRAP_EN (see lsu_align)                     |
// +------------------------------------------------------------------------+
// Ports:
//   clk     clock, rising edge
//   resetn  asynchronous reset, active HIGH despite the name
//   bus     load_store_unit_if.slave: core handshake and memory port
// Flow: IDLE -> ACCESS -> (load) CAPTURE -> RESP -> IDLE; illegal requests
// go IDLE -> RESP directly. All memory-side outputs come from flops loaded
// at the request handshake, so nothing on req_* reaches mem_* in the same
// cycle.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 10
) (
  input  logic                clk,
  input  logic                resetn,
  load_store_unit_if.slave    bus
);

  if (ADDR_W < MEM_AW + 2) begin : g_width_check
    $error("load_store_unit: ADDR_W must cover MEM_AW word-address bits");
  end

  lsu_state_t        r_state;
  lsu_state_t        w_next;

  logic [2:0]        r_funct3;
  logic [1:0]        r_addr_lo;
  logic              r_we;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_mem_en;
  logic [3:0]        r_mem_we;
  logic [MEM_AW-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;

  logic              w_accept;
  logic              w_illegal;
  logic [1:0]        w_eff_addr_lo;
  logic [3:0]        w_strobe;
  logic [31:0]       w_lanes;
  logic [31:0]       w_ld_data;

  lsu_align u_align (
    .req_funct3  (bus.req_funct3),
    .req_we      (bus.req_we),
    .req_addr_lo (bus.req_addr[1:0]),
    .req_wdata   (bus.req_wdata),
    .req_illegal (w_illegal),
    .eff_addr_lo (w_eff_addr_lo),
    .req_strobe  (w_strobe),
    .req_lanes   (w_lanes),
    .ld_funct3   (r_funct3),
    .ld_addr_lo  (r_addr_lo),
    .ld_word     (bus.mem_rdata),
    .ld_data     (w_ld_data)
  );

  assign w_accept = (r_state == ST_IDLE) && bus.req_valid;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (bus.req_valid) w_next = w_illegal ? ST_RESP : ST_ACCESS;
      ST_ACCESS:  w_next = r_we ? ST_RESP : ST_CAPTURE;
      ST_CAPTURE: w_next = ST_RESP;
      ST_RESP:    if (bus.rsp_ready) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_funct3    <= 3'b000;
      r_addr_lo   <= 2'b00;
      r_we        <= 1'b0;
      r_rsp_rdata <= 32'b0;
      r_rsp_err   <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 4'b0000;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'b0;
    end else begin
      // The access strobe lives for exactly the ACCESS cycle.
      r_mem_en <= 1'b0;
      r_mem_we <= 4'b0000;
      if (w_accept) begin
        r_funct3    <= bus.req_funct3;
        r_addr_lo   <= w_eff_addr_lo;
        r_we        <= bus.req_we;
        r_rsp_rdata <= 32'b0;
        r_rsp_err   <= w_illegal;
        if (!w_illegal) begin
          r_mem_en    <= 1'b1;
          r_mem_we    <= bus.req_we ? w_strobe : 4'b0000;
          r_mem_addr  <= bus.req_addr[MEM_AW+1:2];
          r_mem_wdata <= w_lanes;
        end
      end
      // mem_rdata is valid in CAPTURE, one cycle after the read strobe.
      if (r_state == ST_CAPTURE) begin
        r_rsp_rdata <= w_ld_data;
      end
    end
  end

  assign bus.req_ready = (r_state == ST_IDLE);
  assign bus.rsp_valid = (r_state == ST_RESP);
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire
